fb_port_scheduler: RTL

- Time-division scheduler for the single-port frame-buffer RAM in the OV7670→VGA path.
- Shares the one RAM port between the camera pixel writer (buffered through an internal FIFO) and the VGA scan-out reader.
- The frame buffer is FB_W x FB_H; VGA output is 2x upscaled, so each buffer pixel is read once per column pair and each buffer line is read for two VGA rows.
- VGA reads get hard priority on their slots; camera writes drain on every other cycle.

---
 rtl/fb_port_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fb_port_scheduler.sv
// fb_port_scheduler
// Time-division scheduler for the single-port frame-buffer RAM between the
// camera writer and the 2x-upscaled VGA scan-out reader.
//
// Ports:
//   clk, rst_n                  pixel clock, async active-low reset
//   row, col, valid             VGA timing position and active-area flag
//   cam_wr_valid/addr/data      camera pixel write request
//   cam_wr_ready                camera FIFO has room
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata        single RAM port (reads return 1 cycle later)
//   pix_out, pix_valid          pixel stream to the DAC, 3 clk behind row/col
//   ovf, drop_cnt               sticky drop flag and saturating drop count
module fb_port_scheduler #(
    parameter int FB_W       = 320,
    parameter int FB_H       = 240,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        row,
    input  logic [9:0]        col,
    input  logic              valid,
    input  logic              cam_wr_valid,
    input  logic [ADDR_W-1:0] cam_wr_addr,
    input  logic [DATA_W-1:0] cam_wr_data,
    output logic              cam_wr_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] pix_out,
    output logic              pix_valid,
    output logic              ovf,
    output logic [15:0]       drop_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (FB_W * FB_H > (1 << ADDR_W)) begin : g_addr_check
        $error("fb_port_scheduler: FB_W*FB_H does not fit in ADDR_W");
    end
    if (FIFO_DEPTH < 2 || (1 << PTR_W) != FIFO_DEPTH) begin : g_depth_check
        $error("fb_port_scheduler: FIFO_DEPTH must be a power of 2, >= 2");
    end

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] line_base;
    logic              read_slot;
    logic              write_slot;
    logic              push;
    logic              drop;

    logic              rd_d2;
    logic              vld_d1;
    logic              vld_d2;

    // Even active columns own the RAM; everything else may drain the FIFO.
    always_comb begin
        read_slot    = valid && !col[0];
        write_slot   = !read_slot && (count != '0);
        cam_wr_ready = (count < CNT_W'(FIFO_DEPTH));
        push         = cam_wr_valid && cam_wr_ready;
        drop         = cam_wr_valid && !cam_wr_ready;
    end

    // FIFO storage carries no reset; only pointers/count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cam_wr_addr;
            fifo_data[wr_ptr] <= cam_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (write_slot)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, write_slot})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Odd rows advance the base at the start of horizontal blanking, so each
    // buffer line is fetched for an even/odd VGA row pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base <= '0;
        end else if (row == 10'd480 && col == 10'd0) begin
            line_base <= '0;
        end else if (col == 10'd640 && row[0] && row < 10'd479) begin
            line_base <= line_base + ADDR_W'(FB_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else if (read_slot) begin
            ram_en   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= line_base + ADDR_W'(col[9:1]);
        end else if (write_slot) begin
            ram_en    <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= fifo_addr[rd_ptr];
            ram_wdata <= fifo_data[rd_ptr];
        end else begin
            ram_en <= 1'b0;
            ram_we <= 1'b0;
        end
    end

    // Read data lands two cycles after the slot decision; it is latched and
    // held so the odd column repeats the even column's pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d2     <= 1'b0;
            vld_d1    <= 1'b0;
            vld_d2    <= 1'b0;
            pix_valid <= 1'b0;
            pix_out   <= '0;
        end else begin
            rd_d2     <= ram_en && !ram_we;
            vld_d1    <= valid;
            vld_d2    <= vld_d1;
            pix_valid <= vld_d2;
            if (!vld_d2)
                pix_out <= '0;
            else if (rd_d2)
                pix_out <= ram_rdata;
        end
    end

endmodule
